// File: rtl/vga_text_console_writer_if.sv
// Character-stream and VRAM-port bundle for the VGA text console writer.
// The writer is the master of both the stream acknowledge and the VRAM bus.
interface vga_text_console_writer_if;
  logic        CH_VALID;
  logic        CH_READY;
  logic [7:0]  CH_DATA;
  logic        ATTR_IV;
  logic [3:0]  ATTR_FG;
  logic [3:0]  ATTR_BG;
  logic [10:0] VRAM_ADDR;
  logic        VRAM_WE;
  logic [3:0]  VRAM_BYTE_EN;
  logic [31:0] VRAM_WDATA;
  logic [31:0] VRAM_RDATA;

  modport master (
    input  CH_VALID, CH_DATA, ATTR_IV, ATTR_FG, ATTR_BG, VRAM_RDATA,
    output CH_READY, VRAM_ADDR, VRAM_WE, VRAM_BYTE_EN, VRAM_WDATA
  );

  modport slave (
    output CH_VALID, CH_DATA, ATTR_IV, ATTR_FG, ATTR_BG, VRAM_RDATA,
    input  CH_READY, VRAM_ADDR, VRAM_WE, VRAM_BYTE_EN, VRAM_WDATA
  );
endinterface

// File: rtl/vga_text_console_writer.sv
// Terminal engine: turns an ASCII byte stream into glyph writes in the text VRAM,
// handling cursor control codes, end-of-line wrap, scroll-up and full-screen clear.
module vga_text_console_writer #(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 30,
  parameter logic [6:0] BLANK_CODE = 7'h20
) (
  input  logic                             CLK,
  input  logic                             RESET,
  vga_text_console_writer_if.master        bus,
  output logic [6:0]                       CURSOR_COL,
  output logic [4:0]                       CURSOR_ROW,
  output logic                             BUSY
);
  localparam logic [6:0]  LAST_COL    = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW    = 5'(ROWS - 1);
  localparam logic [10:0] ROW_WORDS   = 11'(COLS / 2);
  localparam logic [10:0] LAST_SCROLL = 11'((ROWS - 1) * COLS / 2 - 1);
  localparam logic [10:0] LAST_WORD   = 11'(ROWS * COLS / 2 - 1);

  typedef enum logic [2:0] {
    IDLE, WRITE_CHAR, SCROLL_RD, SCROLL_WR, FILL, CLEAR_ALL
  } state_t;

  state_t      state, state_d;
  logic [6:0]  col, col_d;
  logic [4:0]  row, row_d;
  logic [10:0] ptr, ptr_d;
  logic        iv_q;
  logic [6:0]  code_q;
  logic [3:0]  fg_q, bg_q;

  logic        accept;
  logic [15:0] char_entry;
  logic [15:0] blank_entry;
  logic [10:0] char_word;

  assign accept      = bus.CH_VALID && (state == IDLE);
  assign char_entry  = {iv_q, code_q, fg_q, bg_q};
  assign blank_entry = {1'b0, BLANK_CODE, fg_q, bg_q};
  // COLS is even, so the word index is row*COLS/2 + col/2 and col[0] picks the
  // half; this keeps the 11-bit product from overflowing on the lower rows.
  assign char_word   = 11'(row) * ROW_WORDS + 11'(col[6:1]);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= IDLE;
      col    <= '0;
      row    <= '0;
      ptr    <= '0;
      iv_q   <= 1'b0;
      code_q <= '0;
      fg_q   <= '0;
      bg_q   <= '0;
      BUSY   <= 1'b0;
    end else begin
      state <= state_d;
      col   <= col_d;
      row   <= row_d;
      ptr   <= ptr_d;
      BUSY  <= (state_d != IDLE);
      if (accept) begin
        iv_q   <= bus.ATTR_IV;
        code_q <= bus.CH_DATA[6:0];
        fg_q   <= bus.ATTR_FG;
        bg_q   <= bus.ATTR_BG;
      end
    end
  end

  assign CURSOR_COL = col;
  assign CURSOR_ROW = row;

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_d          = state;
    col_d            = col;
    row_d            = row;
    ptr_d            = ptr;
    bus.CH_READY     = 1'b0;
    bus.VRAM_ADDR    = '0;
    bus.VRAM_WE      = 1'b0;
    bus.VRAM_BYTE_EN = '0;
    bus.VRAM_WDATA   = '0;

    unique case (state)
      IDLE: begin
        bus.CH_READY = 1'b1;
        if (bus.CH_VALID) begin
          unique case (bus.CH_DATA)
            8'h0D: col_d = '0;
            8'h0A: begin
              col_d = '0;
              if (row == LAST_ROW) begin
                state_d = SCROLL_RD;
                ptr_d   = '0;
              end else begin
                row_d = row + 5'd1;
              end
            end
            8'h08: if (col != '0) col_d = col - 7'd1;
            8'h0C: begin
              state_d = CLEAR_ALL;
              ptr_d   = '0;
            end
            default: if (bus.CH_DATA >= 8'h20) state_d = WRITE_CHAR;
          endcase
        end
      end

      WRITE_CHAR: begin
        bus.VRAM_ADDR    = char_word;
        bus.VRAM_WE      = 1'b1;
        bus.VRAM_BYTE_EN = col[0] ? 4'b1100 : 4'b0011;
        bus.VRAM_WDATA   = {char_entry, char_entry};
        state_d          = IDLE;
        if (col == LAST_COL) begin
          col_d = '0;
          if (row == LAST_ROW) begin
            state_d = SCROLL_RD;
            ptr_d   = '0;
          end else begin
            row_d = row + 5'd1;
          end
        end else begin
          col_d = col + 7'd1;
        end
      end

      // Each word moves up one text row: read it a row below, write it back here.
      SCROLL_RD: begin
        bus.VRAM_ADDR = ptr + ROW_WORDS;
        state_d       = SCROLL_WR;
      end

      SCROLL_WR: begin
        bus.VRAM_ADDR    = ptr;
        bus.VRAM_WE      = 1'b1;
        bus.VRAM_BYTE_EN = 4'b1111;
        bus.VRAM_WDATA   = bus.VRAM_RDATA;
        ptr_d            = ptr + 11'd1;
        state_d          = (ptr == LAST_SCROLL) ? FILL : SCROLL_RD;
      end

      FILL, CLEAR_ALL: begin
        bus.VRAM_ADDR    = ptr;
        bus.VRAM_WE      = 1'b1;
        bus.VRAM_BYTE_EN = 4'b1111;
        bus.VRAM_WDATA   = {blank_entry, blank_entry};
        ptr_d            = ptr + 11'd1;
        if (ptr == LAST_WORD) begin
          state_d = IDLE;
          if (state == CLEAR_ALL) begin
            col_d = '0;
            row_d = '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_vga_text_console_writer.sv
// Self-checking bench for vga_text_console_writer: a VRAM model, a write
// scoreboard, a table of single-byte vectors and hand sequences for scroll/clear/reset.
module tb_vga_text_console_writer;
  localparam int WORDS = 1200;

  logic       CLK;
  logic       RESET;
  logic [6:0] CURSOR_COL;
  logic [4:0] CURSOR_ROW;
  logic       BUSY;

  vga_text_console_writer_if bus ();

  vga_text_console_writer #(.COLS(80), .ROWS(30), .BLANK_CODE(7'h20)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus),
    .CURSOR_COL(CURSOR_COL),
    .CURSOR_ROW(CURSOR_ROW),
    .BUSY      (BUSY)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  typedef struct {
    logic [10:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } wr_t;

  typedef struct {
    logic [7:0]  data;
    logic        iv;
    logic [3:0]  fg;
    logic [3:0]  bg;
    logic        we;
    logic [10:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [6:0]  col;
    logic [4:0]  row;
    int          busy;
  } vec_t;

  wr_t         exp_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  bit          sb_on  = 1'b1;
  bit          preload = 1'b0;
  logic [31:0] mem [0:WORDS-1];

  function automatic logic [31:0] pat(input int i);
    return {16'(i) ^ 16'h5A00, 16'(i * 3 + 7)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // VRAM model: byte-enabled writes, read data one cycle after the address.
  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= pat(i);
    end else if (bus.VRAM_WE && bus.VRAM_ADDR < 11'd1200) begin
      for (int b = 0; b < 4; b++)
        if (bus.VRAM_BYTE_EN[b]) mem[bus.VRAM_ADDR][8*b +: 8] <= bus.VRAM_WDATA[8*b +: 8];
    end
    bus.VRAM_RDATA <= (bus.VRAM_ADDR < 11'd1200) ? mem[bus.VRAM_ADDR] : 32'h0;
  end

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge CLK) begin
    if (RESET && sb_on && bus.VRAM_WE) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", {63'd0, bus.VRAM_WE}, 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check($sformatf("vram_write@%0d", e.addr),
              {17'd0, bus.VRAM_ADDR, bus.VRAM_BYTE_EN, bus.VRAM_WDATA},
              {17'd0, e.addr, e.be, e.wdata});
      end
    end
  end

  task automatic push_wr(input logic [10:0] addr, input logic [3:0] be, input logic [31:0] wdata);
    wr_t e;
    e.addr  = addr;
    e.be    = be;
    e.wdata = wdata;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] d, input logic iv, input logic [3:0] fg, input logic [3:0] bg);
    int guard = 0;
    @(negedge CLK);
    bus.CH_VALID = 1'b1;
    bus.CH_DATA  = d;
    bus.ATTR_IV  = iv;
    bus.ATTR_FG  = fg;
    bus.ATTR_BG  = bg;
    while (!bus.CH_READY && guard < 5000) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 5000) check("ready_timeout", {63'd0, bus.CH_READY}, 64'd1);
    @(posedge CLK);
    #1 bus.CH_VALID = 1'b0;
  endtask

  task automatic count_busy(output int cyc);
    cyc = 0;
    while (BUSY && cyc < 10000) begin
      cyc++;
      @(negedge CLK);
    end
    if (cyc >= 10000) check("busy_timeout", {63'd0, BUSY}, 64'd0);
  endtask

  task automatic wait_idle(output int cyc);
    @(negedge CLK);
    count_busy(cyc);
  endtask

  task automatic check_cursor(input string name, input logic [6:0] col, input logic [4:0] row);
    check(name, {52'd0, CURSOR_ROW, CURSOR_COL}, {52'd0, row, col});
  endtask

  vec_t vecs[11];

  initial begin
    int          cyc;
    int          guard;
    logic [7:0]  d;
    logic [3:0]  fg;
    logic [15:0] ent;

    vecs[0]  = '{8'h41, 1'b0, 4'h2, 4'h1, 1'b1, 11'd0,  4'h3, 32'h41214121, 7'd1, 5'd0, 1};
    vecs[1]  = '{8'h42, 1'b1, 4'hF, 4'h0, 1'b1, 11'd0,  4'hC, 32'hC2F0C2F0, 7'd2, 5'd0, 1};
    vecs[2]  = '{8'h0D, 1'b0, 4'h0, 4'h0, 1'b0, 11'd0,  4'h0, 32'h0,        7'd0, 5'd0, 0};
    vecs[3]  = '{8'h0A, 1'b0, 4'h0, 4'h0, 1'b0, 11'd0,  4'h0, 32'h0,        7'd0, 5'd1, 0};
    vecs[4]  = '{8'h08, 1'b0, 4'h0, 4'h0, 1'b0, 11'd0,  4'h0, 32'h0,        7'd0, 5'd1, 0};
    vecs[5]  = '{8'h58, 1'b0, 4'h7, 4'h3, 1'b1, 11'd40, 4'h3, 32'h58735873, 7'd1, 5'd1, 1};
    vecs[6]  = '{8'h79, 1'b0, 4'h0, 4'h0, 1'b1, 11'd40, 4'hC, 32'h79007900, 7'd2, 5'd1, 1};
    vecs[7]  = '{8'h08, 1'b0, 4'h0, 4'h0, 1'b0, 11'd0,  4'h0, 32'h0,        7'd1, 5'd1, 0};
    vecs[8]  = '{8'h07, 1'b0, 4'h0, 4'h0, 1'b0, 11'd0,  4'h0, 32'h0,        7'd1, 5'd1, 0};
    vecs[9]  = '{8'hC1, 1'b1, 4'h5, 4'h6, 1'b1, 11'd40, 4'hC, 32'hC156C156, 7'd2, 5'd1, 1};
    vecs[10] = '{8'h1B, 1'b0, 4'h0, 4'h0, 1'b0, 11'd0,  4'h0, 32'h0,        7'd2, 5'd1, 0};

    bus.CH_VALID = 1'b0;
    bus.CH_DATA  = '0;
    bus.ATTR_IV  = 1'b0;
    bus.ATTR_FG  = '0;
    bus.ATTR_BG  = '0;
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("rst_ready", {63'd0, bus.CH_READY}, 64'd1);
    check("rst_busy", {63'd0, BUSY}, 64'd0);
    check("rst_vram", {17'd0, bus.VRAM_ADDR, bus.VRAM_WE, bus.VRAM_BYTE_EN, bus.VRAM_WDATA}, 64'd0);
    check_cursor("rst_cursor", 7'd0, 5'd0);

    // Single-byte vectors: write placement, control codes, ignored codes.
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].we) push_wr(vecs[i].addr, vecs[i].be, vecs[i].wdata);
      send(vecs[i].data, vecs[i].iv, vecs[i].fg, vecs[i].bg);
      wait_idle(cyc);
      check($sformatf("v%0d_busy", i), 64'(cyc), 64'(vecs[i].busy));
      check_cursor($sformatf("v%0d_cursor", i), vecs[i].col, vecs[i].row);
      check($sformatf("v%0d_ready", i), {63'd0, bus.CH_READY}, 64'd1);
    end
    check("vec_drain", 64'(exp_q.size()), 64'd0);

    // Form feed mid-screen: 1200 blank words, cursor home.
    for (int a = 0; a < WORDS; a++) push_wr(11'(a), 4'hF, 32'h20342034);
    send(8'h0C, 1'b0, 4'h3, 4'h4);
    wait_idle(cyc);
    check("clear_busy", 64'(cyc), 64'd1200);
    check_cursor("clear_cursor", 7'd0, 5'd0);
    check("clear_drain", 64'(exp_q.size()), 64'd0);

    // A full row of printable bytes wraps to the next row.
    for (int i = 0; i < 80; i++) begin
      d   = 8'h30 + 8'(i % 40);
      fg  = 4'(i);
      ent = {i[1], d[6:0], fg, ~fg};
      push_wr(11'(i / 2), i[0] ? 4'hC : 4'h3, {ent, ent});
      send(d, i[1], fg, ~fg);
      wait_idle(cyc);
    end
    check_cursor("wrap_cursor", 7'd0, 5'd1);
    check("wrap_drain", 64'(exp_q.size()), 64'd0);

    // Backspace at column 0 is a no-op.
    send(8'h0A, 1'b0, 4'h0, 4'h0);
    send(8'h0A, 1'b0, 4'h0, 4'h0);
    send(8'h08, 1'b0, 4'h0, 4'h0);
    wait_idle(cyc);
    check_cursor("bs_col0_cursor", 7'd0, 5'd3);

    // Move to the last row and write five glyphs there.
    for (int i = 0; i < 26; i++) send(8'h0A, 1'b0, 4'h0, 4'h0);
    wait_idle(cyc);
    check_cursor("lastrow_cursor", 7'd0, 5'd29);
    for (int i = 0; i < 5; i++) begin
      d   = 8'h61 + 8'(i);
      ent = {1'b0, d[6:0], 4'h1, 4'h2};
      push_wr(11'(1160 + i / 2), i[0] ? 4'hC : 4'h3, {ent, ent});
      send(d, 1'b0, 4'h1, 4'h2);
      wait_idle(cyc);
    end
    check_cursor("row29_cursor", 7'd5, 5'd29);
    check("row29_drain", 64'(exp_q.size()), 64'd0);

    // Line feed on the last row: scroll up and blank-fill the bottom row.
    @(negedge CLK) preload = 1'b1;
    @(negedge CLK) preload = 1'b0;
    for (int p = 0; p < 1160; p++) push_wr(11'(p), 4'hF, pat(p + 40));
    for (int a = 1160; a < WORDS; a++) push_wr(11'(a), 4'hF, 32'h20A520A5);
    send(8'h0A, 1'b0, 4'hA, 4'h5);
    @(negedge CLK);
    check("scroll_first_rd", {51'd0, bus.VRAM_ADDR, 1'b0, bus.VRAM_WE}, {51'd0, 11'd40, 1'b0, 1'b0});
    count_busy(cyc);
    check("scroll_busy", 64'(cyc), 64'd2360);
    check_cursor("scroll_cursor", 7'd0, 5'd29);
    check("scroll_drain", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a scroll abandons it immediately.
    sb_on = 1'b0;
    send(8'h0A, 1'b0, 4'h0, 4'h0);
    guard = 0;
    @(negedge CLK);
    while (!(bus.VRAM_WE && bus.VRAM_ADDR == 11'd500) && guard < 3000) begin
      @(negedge CLK);
      guard++;
    end
    check("midscroll_reached", {63'd0, bus.VRAM_WE}, 64'd1);
    RESET = 1'b0;
    #1;
    check("midrst_we", {63'd0, bus.VRAM_WE}, 64'd0);
    check("midrst_busy", {63'd0, BUSY}, 64'd0);
    check_cursor("midrst_cursor", 7'd0, 5'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    exp_q.delete();
    sb_on = 1'b1;
    @(negedge CLK);
    check("postrst_ready", {63'd0, bus.CH_READY}, 64'd1);
    push_wr(11'd0, 4'h3, 32'h51005100);
    send(8'h51, 1'b0, 4'h0, 4'h0);
    wait_idle(cyc);
    check_cursor("postrst_cursor", 7'd1, 5'd0);
    check("postrst_drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
